// File: rtl/dsp_audio_pkg.sv
// Shared audio-path types: sample width, channel count and the I2S framer state encoding.
package dsp_audio_pkg;

  localparam int IO_WIDTH     = 24;
  localparam int NUM_LANES    = 4;
  localparam int NUM_CHANNELS = 2 * NUM_LANES;

  typedef logic [IO_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } framer_state_t;

endpackage

// File: rtl/i2s_lane_deser.sv
// One I2S data lane: assembles the current half-frame word and holds the finished left word.
module i2s_lane_deser #(
  parameter int IO_WIDTH = 24,
  parameter int IDX_W    = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic                bit_in,
  input  logic                latch_left,
  output logic [IO_WIDTH-1:0] left_word,
  output logic [IO_WIDTH-1:0] cur_word
);

  logic [IO_WIDTH-1:0] shreg;

  // Bits land MSB-first at their final position, so a short half-frame leaves its LSBs zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg     <= '0;
      left_word <= '0;
    end else begin
      if (latch_left) left_word <= shreg;
      if (clr) begin
        shreg <= '0;
      end else if (wr_en) begin
        shreg[wr_idx] <= bit_in;
      end
    end
  end

  assign cur_word = shreg;

endmodule

// File: rtl/i2s_rx_framer.sv
// I2S receive framer: synchronizes bclk/lrck/sdata into clk and publishes complete stereo frames.
// Optional macro I2S_RX_ERR_CHECK_EN adds the frame_err short-half-frame flag.
//   state    | meaning
//   ST_SYNC  | waiting for the first lrck falling edge after reset
//   ST_LEFT  | collecting left words of all lanes
//   ST_RIGHT | collecting right words; left words parked in holding registers
module i2s_rx_framer #(
  parameter int IO_WIDTH  = dsp_audio_pkg::IO_WIDTH,
  parameter int NUM_LANES = dsp_audio_pkg::NUM_LANES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 bclk,
  input  logic                 lrck,
  input  logic [NUM_LANES-1:0] sdata,
  output logic [IO_WIDTH-1:0]  audio_inputs [0:2*NUM_LANES-1],
  output logic                 frame_valid
`ifdef I2S_RX_ERR_CHECK_EN
  ,
  output logic                 frame_err
`endif
);

  import dsp_audio_pkg::*;

  localparam int CW    = $clog2(IO_WIDTH + 2);
  localparam int IDX_W = (IO_WIDTH > 1) ? $clog2(IO_WIDTH) : 1;
  localparam int NCH   = 2 * NUM_LANES;

  logic [2:0]           bclk_sync;
  logic [2:0]           lrck_sync;
  logic [NUM_LANES-1:0] sdata_s1;
  logic [NUM_LANES-1:0] sdata_s2;

  logic                 rise_q;
  logic                 chg_q;
  logic                 lr_q;
  logic [NUM_LANES-1:0] bits_q;

  framer_state_t        state;
  logic [CW-1:0]        bit_cnt;
  logic                 in_word;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic                 latch_left;

  logic [IO_WIDTH-1:0]  left_words [NUM_LANES];
  logic [IO_WIDTH-1:0]  cur_words  [NUM_LANES];

`ifdef I2S_RX_ERR_CHECK_EN
  logic                 left_short;
`endif

  // Sync stage [1] is compared with [2]; edge events and the sampled bits are registered together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      sdata_s1  <= '0;
      sdata_s2  <= '0;
      rise_q    <= 1'b0;
      chg_q     <= 1'b0;
      lr_q      <= 1'b0;
      bits_q    <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], bclk};
      lrck_sync <= {lrck_sync[1:0], lrck};
      sdata_s1  <= sdata;
      sdata_s2  <= sdata_s1;
      rise_q    <= bclk_sync[1] & ~bclk_sync[2];
      chg_q     <= lrck_sync[1] ^ lrck_sync[2];
      lr_q      <= lrck_sync[1];
      bits_q    <= sdata_s2;
    end
  end

  assign in_word    = (bit_cnt != '0) && (bit_cnt <= CW'(IO_WIDTH));
  assign wr_en      = rise_q && !chg_q && in_word;
  assign wr_idx     = IDX_W'(CW'(IO_WIDTH) - bit_cnt);
  assign latch_left = chg_q && lr_q && (state == ST_LEFT);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    i2s_lane_deser #(
      .IO_WIDTH (IO_WIDTH),
      .IDX_W    (IDX_W)
    ) u_deser (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr        (chg_q),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .bit_in     (bits_q[k]),
      .latch_left (latch_left),
      .left_word  (left_words[k]),
      .cur_word   (cur_words[k])
    );
  end

  // A bclk edge coinciding with an lrck change is index 0 of the new half-frame, so the count restarts at 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_SYNC;
      bit_cnt     <= '0;
      frame_valid <= 1'b0;
      for (int i = 0; i < NCH; i++) audio_inputs[i] <= '0;
`ifdef I2S_RX_ERR_CHECK_EN
      left_short  <= 1'b0;
      frame_err   <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
`ifdef I2S_RX_ERR_CHECK_EN
      frame_err   <= 1'b0;
`endif
      if (chg_q) begin
        bit_cnt <= rise_q ? CW'(1) : '0;
        case (state)
          ST_SYNC: begin
            if (!lr_q) state <= ST_LEFT;
          end
          ST_LEFT: begin
            if (lr_q) begin
              state <= ST_RIGHT;
`ifdef I2S_RX_ERR_CHECK_EN
              left_short <= (bit_cnt < CW'(IO_WIDTH + 1));
`endif
            end
          end
          ST_RIGHT: begin
            if (!lr_q) begin
              state       <= ST_LEFT;
              frame_valid <= 1'b1;
              for (int k = 0; k < NUM_LANES; k++) begin
                audio_inputs[2*k]   <= left_words[k];
                audio_inputs[2*k+1] <= cur_words[k];
              end
`ifdef I2S_RX_ERR_CHECK_EN
              frame_err <= left_short | (bit_cnt < CW'(IO_WIDTH + 1));
`endif
            end
          end
          default: state <= ST_SYNC;
        endcase
      end else if (rise_q && (bit_cnt != CW'(IO_WIDTH + 1))) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_framer.sv
// Self-checking bench for i2s_rx_framer; frame_err checks follow I2S_RX_ERR_CHECK_EN.
module tb_i2s_rx_framer;

  localparam int W   = 24;
  localparam int L   = 4;
  localparam int NCH = 2 * L;
  localparam int NRAND = 150;

  typedef struct packed {
    logic                   err;
    logic [NCH-1:0][W-1:0]  w;
  } frame_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          bclk = 1'b0;
  logic          lrck = 1'b0;
  logic [L-1:0]  sdata = '0;
  logic [W-1:0]  audio_inputs [0:NCH-1];
  logic          frame_valid;
`ifdef I2S_RX_ERR_CHECK_EN
  logic          frame_err;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int n_valid = 0;
  frame_t exp_q[$];
  frame_t mon_e;
  logic   mon_same;
  logic [W-1:0] prev [0:NCH-1];

  i2s_rx_framer #(.IO_WIDTH(W), .NUM_LANES(L)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bclk         (bclk),
    .lrck         (lrck),
    .sdata        (sdata),
    .audio_inputs (audio_inputs),
    .frame_valid  (frame_valid)
`ifdef I2S_RX_ERR_CHECK_EN
    ,
    .frame_err    (frame_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a published word keeps its first (n-1) received bits MSB-first, the rest are zero.
  function automatic logic [W-1:0] zfill(input logic [W-1:0] w, input int n);
    logic [W-1:0] m;
    int b;
    b = n - 1;
    if (b > W) b = W;
    if (b < 0) b = 0;
    m = '1;
    m = (b == 0) ? '0 : ~(m >> b);
    return w & m;
  endfunction

  function automatic logic [L-1:0][W-1:0] rnd_words();
    logic [L-1:0][W-1:0] r;
    for (int k = 0; k < L; k++) r[k] = W'($urandom);
    return r;
  endfunction

  // Monitor: scoreboard on frame_valid, hold check otherwise.
  always @(negedge clk) begin
    if (reset_n && frame_valid) begin
      n_valid++;
      total++;
      assert (exp_q.size() > 0) else begin
        bad++; $error("FAIL unexpected_valid got=1 exp=0 at cyc %0d", cyc);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        for (int ch = 0; ch < NCH; ch++) begin
          total++;
          assert (audio_inputs[ch] === mon_e.w[ch]) else begin
            bad++; $error("FAIL chan%0d got=%h exp=%h", ch, audio_inputs[ch], mon_e.w[ch]);
          end
        end
`ifdef I2S_RX_ERR_CHECK_EN
        total++;
        assert (frame_err === mon_e.err) else begin
          bad++; $error("FAIL frame_err got=%b exp=%b", frame_err, mon_e.err);
        end
`endif
        total++;
        assert (cyc - fall_cyc == 4) else begin
          bad++; $error("FAIL latency got=%0d exp=4", cyc - fall_cyc);
        end
      end
    end else if (reset_n) begin
      mon_same = 1'b1;
      for (int ch = 0; ch < NCH; ch++) if (audio_inputs[ch] !== prev[ch]) mon_same = 1'b0;
      total++;
      assert (mon_same === 1'b1) else begin
        bad++; $error("FAIL hold_between_frames got=changed exp=stable at cyc %0d", cyc);
      end
`ifdef I2S_RX_ERR_CHECK_EN
      total++;
      assert (frame_err === 1'b0) else begin
        bad++; $error("FAIL err_without_valid got=%b exp=0", frame_err);
      end
`endif
    end
    for (int ch = 0; ch < NCH; ch++) prev[ch] = audio_inputs[ch];
  end

  // One bclk period: low phase then high phase, two clk each; lrck may differ between phases.
  task automatic send_bit(input logic lr_lo, input logic lr_hi, input logic [L-1:0] d);
    if (lrck && !lr_lo) fall_cyc = cyc;
    bclk = 1'b0; lrck = lr_lo; sdata = d;
    repeat (2) @(negedge clk);
    if (lrck && !lr_hi) fall_cyc = cyc;
    bclk = 1'b1; lrck = lr_hi;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_half(input logic lr, input bit coinc, input logic [L-1:0][W-1:0] wd, input int n);
    logic [L-1:0] d;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < L; k++) d[k] = (i >= 1 && i <= W) ? wd[k][W-i] : 1'($urandom);
      send_bit((i == 0 && coinc) ? lrck : lr, lr, d);
    end
  endtask

  task automatic send_frame(input logic [L-1:0][W-1:0] lw, input logic [L-1:0][W-1:0] rw,
                            input int nl, input int nr, input bit expect_it, input bit coinc);
    frame_t e;
    send_half(1'b0, coinc, lw, nl);
    send_half(1'b1, coinc, rw, nr);
    if (expect_it) begin
      for (int k = 0; k < L; k++) begin
        e.w[2*k]   = zfill(lw[k], nl);
        e.w[2*k+1] = zfill(rw[k], nr);
      end
      e.err = (nl < W + 1) || (nr < W + 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (ncyc) @(negedge clk);
    for (int ch = 0; ch < NCH; ch++) begin
      total++;
      assert (audio_inputs[ch] === '0) else begin
        bad++; $error("FAIL reset_chan%0d got=%h exp=0", ch, audio_inputs[ch]);
      end
    end
    total++;
    assert (frame_valid === 1'b0) else begin
      bad++; $error("FAIL reset_valid got=%b exp=0", frame_valid);
    end
`ifdef I2S_RX_ERR_CHECK_EN
    total++;
    assert (frame_err === 1'b0) else begin
      bad++; $error("FAIL reset_err got=%b exp=0", frame_err);
    end
`endif
    reset_n = 1'b1;
  endtask

  // Trailing lrck fall releases the last frame, then every expected frame must have arrived.
  task automatic finish_scn(input string tag, input int nv0, input int nexp);
    send_half(1'b0, 1'b0, rnd_words(), 6);
    repeat (8) @(negedge clk);
    total++;
    assert (exp_q.size() == 0) else begin
      bad++; $error("FAIL %s_pending got=%0d exp=0", tag, exp_q.size());
    end
    total++;
    assert (n_valid - nv0 == nexp) else begin
      bad++; $error("FAIL %s_valid_count got=%0d exp=%0d", tag, n_valid - nv0, nexp);
    end
  endtask

  initial begin
    logic [L-1:0][W-1:0] lw, rw;
    int nv0, nl, nr;
    bit cc;

    // Known pattern on lane 0, started in the middle of a right half.
    do_reset(4);
    nv0 = n_valid;
    send_half(1'b1, 1'b0, rnd_words(), 10);
    lw = rnd_words(); rw = rnd_words();
    lw[0] = 24'h123456; rw[0] = 24'hABCDEF;
    send_frame(lw, rw, 32, 32, 1'b1, 1'b0);
    finish_scn("pattern", nv0, 1);

    // Distinct words on every lane, all published together.
    do_reset(2);
    nv0 = n_valid;
    send_half(1'b1, 1'b0, rnd_words(), 32);
    for (int k = 0; k < L; k++) begin
      lw[k] = 24'h100000 + W'(k);
      rw[k] = 24'h200000 + W'(k);
    end
    send_frame(lw, rw, 32, 32, 1'b1, 1'b0);
    finish_scn("lanes", nv0, 1);

    // Short (16-bit), exactly-full and overlong half-frames.
    do_reset(2);
    nv0 = n_valid;
    send_half(1'b1, 1'b0, rnd_words(), 5);
    for (int k = 0; k < L; k++) begin lw[k] = 24'hBEEF00; rw[k] = 24'hBEEF00; end
    send_frame(lw, rw, 17, 17, 1'b1, 1'b0);
    send_frame(rnd_words(), rnd_words(), W + 1, W + 1, 1'b1, 1'b0);
    send_frame(rnd_words(), rnd_words(), W + 1, 17, 1'b1, 1'b0);
    send_frame(rnd_words(), rnd_words(), 33, 40, 1'b1, 1'b0);
    finish_scn("width", nv0, 4);

    // lrck change detected in the same clk as a bclk rising edge.
    do_reset(2);
    nv0 = n_valid;
    send_half(1'b1, 1'b0, rnd_words(), 8);
    send_frame(rnd_words(), rnd_words(), 26, 26, 1'b1, 1'b1);
    send_frame(rnd_words(), rnd_words(), W + 1, 30, 1'b1, 1'b1);
    finish_scn("coincident", nv0, 2);

    // Reset pulse in the middle of a left half.
    do_reset(2);
    nv0 = n_valid;
    send_half(1'b1, 1'b0, rnd_words(), 8);
    send_frame(rnd_words(), rnd_words(), 32, 32, 1'b1, 1'b0);
    send_half(1'b0, 1'b0, rnd_words(), 10);
    do_reset(3);
    send_half(1'b0, 1'b0, rnd_words(), 14);
    send_half(1'b1, 1'b0, rnd_words(), 25);
    send_frame(rnd_words(), rnd_words(), 30, 28, 1'b1, 1'b0);
    finish_scn("midreset", nv0, 2);

    // Random frames at clk = 4x bclk; the first frame is lost to synchronization.
    do_reset(2);
    nv0 = n_valid;
    for (int f = 0; f < NRAND; f++) begin
      nl = $urandom_range(32, 18);
      nr = $urandom_range(32, 18);
      cc = 1'($urandom);
      send_frame(rnd_words(), rnd_words(), nl, nr, f > 0, cc);
    end
    finish_scn("random", nv0, NRAND - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
